// File: rtl/prach_hb2_split_if.sv
// Sample-stream bundle between the TDM source, prach_hb2_split and prach_hb2_ch.
// master drives the TDM input side; slave is the splitter itself.
interface prach_hb2_split_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] din_dq;
  logic             din_dv;
  logic [7:0]       din_chn;
  logic             sync_in;
  logic [WIDTH-1:0] dout_dp1;
  logic [WIDTH-1:0] dout_dp2;
  logic             dout_dv;
  logic [7:0]       dout_chn;
  logic             sync_out;
  logic             err_chn;

  modport master (
    output din_dq, din_dv, din_chn, sync_in,
    input  dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, err_chn
  );

  modport slave (
    input  din_dq, din_dv, din_chn, sync_in,
    output dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, err_chn
  );
endinterface

// File: rtl/prach_hb2_split.sv
// Pairs consecutive samples of each TDM channel into one (even, odd) output beat,
// halving the per-channel rate ahead of the halfband decimator. Two-stage pipeline.
module prach_hb2_split #(
  parameter int NUM_CHANNEL = 32,
  parameter int WIDTH       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  prach_hb2_split_if.slave  bus
);
  localparam int         CW       = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;
  localparam logic [8:0] NUM_CH_W = 9'(NUM_CHANNEL);

  logic                   in_range;
  logic                   accept;
  logic                   is_odd;
  logic [CW-1:0]          chn_idx;
  logic [NUM_CHANNEL-1:0] hit;
  logic [NUM_CHANNEL-1:0] phase_reg;
  logic [NUM_CHANNEL-1:0] phase_next;

  logic [WIDTH-1:0]       store_mem [NUM_CHANNEL];

  logic                   s1_beat_reg;
  logic                   s1_err_reg;
  logic                   s1_sync_reg;
  logic [7:0]             s1_chn_reg;
  logic [WIDTH-1:0]       s1_odd_reg;
  logic [WIDTH-1:0]       s1_even_reg;

  logic                   dv_reg;
  logic                   err_reg;
  logic                   sync_reg;
  logic [7:0]             chn_reg;
  logic [WIDTH-1:0]       dp1_reg;
  logic [WIDTH-1:0]       dp2_reg;

  assign in_range = {1'b0, bus.din_chn} < NUM_CH_W;
  assign accept   = bus.din_dv & in_range;
  assign chn_idx  = bus.din_chn[CW-1:0];
  // sync wins over the stored phase, so a sample on a sync cycle is always even
  assign is_odd   = accept & ~bus.sync_in & phase_reg[chn_idx];

  generate
    for (genvar gi = 0; gi < NUM_CHANNEL; gi++) begin : g_phase
      assign hit[gi]        = accept && (chn_idx == CW'(gi));
      assign phase_next[gi] = hit[gi] ? (bus.sync_in | ~phase_reg[gi])
                                      : (~bus.sync_in & phase_reg[gi]);
    end
  endgenerate

  // Even-sample store: the write at edge t is visible to the registered read at
  // edge t+1, which covers back-to-back even/odd samples of one channel.
  always_ff @(posedge clk) begin
    if (accept && !is_odd) begin
      store_mem[chn_idx] <= bus.din_dq;
    end
    s1_even_reg <= store_mem[chn_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_reg   <= '0;
      s1_beat_reg <= 1'b0;
      s1_err_reg  <= 1'b0;
      s1_sync_reg <= 1'b0;
      s1_chn_reg  <= '0;
      s1_odd_reg  <= '0;
    end else begin
      phase_reg   <= phase_next;
      s1_beat_reg <= is_odd;
      s1_err_reg  <= bus.din_dv & ~in_range;
      s1_sync_reg <= bus.sync_in;
      s1_chn_reg  <= bus.din_chn;
      s1_odd_reg  <= bus.din_dq;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dv_reg   <= 1'b0;
      err_reg  <= 1'b0;
      sync_reg <= 1'b0;
      chn_reg  <= '0;
      dp1_reg  <= '0;
      dp2_reg  <= '0;
    end else begin
      dv_reg   <= s1_beat_reg;
      err_reg  <= s1_err_reg;
      sync_reg <= s1_sync_reg;
      // pair data holds between beats for the downstream filter
      if (s1_beat_reg) begin
        chn_reg <= s1_chn_reg;
        dp1_reg <= s1_even_reg;
        dp2_reg <= s1_odd_reg;
      end
    end
  end

  assign bus.dout_dv  = dv_reg;
  assign bus.err_chn  = err_reg;
  assign bus.sync_out = sync_reg;
  assign bus.dout_chn = chn_reg;
  assign bus.dout_dp1 = dp1_reg;
  assign bus.dout_dp2 = dp2_reg;
endmodule

// File: doc/prach_hb2_split.md
Name: prach_hb2_split

Overview:
- Polyphase splitter sitting directly upstream of prach_hb2_ch.
- Takes a TDM complex-component sample stream (one 16-bit sample per valid cycle, tagged by channel) and pairs consecutive samples of each channel.
- On the second sample of each pair it emits both samples together as dout_dp1/dout_dp2 on one output beat, halving the per-channel rate for the halfband decimator.
- Per-channel phase state is cleared by the frame sync so pairing is deterministic from PRACH frame start.

Parameters:
- NUM_CHANNEL, 32, number of TDM channels; channel indices 0..NUM_CHANNEL-1 are valid.
- WIDTH, 16, sample width in bits; fixed 16 for prach_hb2_ch compatibility.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- din_dq  input  16  input sample, two's complement
- din_dv  input  1  input sample valid
- din_chn  input  8  channel index of din_dq
- sync_in  input  1  frame sync pulse
- dout_dp1  output  16  first (even) sample of the pair
- dout_dp2  output  16  second (odd) sample of the pair
- dout_dv  output  1  output pair valid
- dout_chn  output  8  channel index of the output pair
- sync_out  output  1  sync_in delayed by 2 cycles
- err_chn  output  1  one-cycle pulse: valid input with out-of-range channel

Behaviour:
- Clocking and reset
  - Single clock domain.
  - Reset is synchronous, active-low, on rst_n sampled at posedge clk.
  - While rst_n=0, all outputs are 0 and all per-channel phase bits are 0.
  - Sample storage RAM contents are don't-care after reset; phase=0 guarantees a stored sample is never read before it is written.
- Per-channel state
  - phase[NUM_CHANNEL] bits, plus NUM_CHANNEL x 16 even-sample store (distributed RAM or registers).
- Input accept
  - Processing happens on any cycle with din_dv=1 and din_chn<NUM_CHANNEL.
  - phase[c]=0: write din_dq to store[c], set phase[c]=1, no output.
  - phase[c]=1: output pair (store[c], din_dq) for channel c, clear phase[c].
- Out-of-range channel
  - A cycle with din_dv=1 and din_chn>=NUM_CHANNEL is dropped: no state change, no output.
  - err_chn pulses 1 exactly 2 cycles later, aligned to the output pipeline.
- Sync
  - When sync_in=1, all phase bits are cleared before the same cycle's sample is evaluated.
  - A valid sample on a sync cycle is therefore treated as an even sample: stored, not output.
  - sync_in with din_dv=0 just clears phase.
- Latency
  - The odd sample at input cycle t produces dout_dv=1 at t+2, with dout_dp1=even sample, dout_dp2=odd sample, dout_chn=c.
  - Stage 1 registers the input, decision and store read. Stage 2 is the output register.
- Output holding
  - dout_dp1, dout_dp2 and dout_chn update only on output beats and hold their last value otherwise.
  - dout_dv and err_chn are 0 on all non-beat cycles.
- sync_out is a pure 2-cycle delay of sync_in, independent of dv, and is reset to 0.
- Timing patterns
  - Gaps in din_dv are allowed anywhere; phase state persists across gaps indefinitely.
  - Channels may arrive in any order; each channel pairs independently.
  - Back-to-back same-channel samples (even at t, odd at t+1) must pair correctly: store write-then-read bypass is required.
- Mid-operation reset
  - Clears all phase bits and flushes both pipeline stages.
  - No output beat emerges for samples accepted before reset.
- Width: no arithmetic; data passes bit-exact.
- Downstream contract
  - prach_hb2_ch consumes dout_dp1/dout_dp2/dout_dv/dout_chn/sync_out directly, without backpressure.
  - Upstream must not present more than one sample per cycle (inherent in the interface).

Test Plan:
- Reset, then sync; channels 0..31 round-robin, din_dq = 100*chn + k (k = sample count per channel) -> every second visit per channel: dout_dv=1, dp1=100c+2m, dp2=100c+2m+1, 2 cycles after the odd sample; 32 beats per round-robin pair.
- Channel 5 at t=10 (0x1234) and t=11 (0x8001), with no sync -> t=13: dv=1, chn=5, dp1=0x1234, dp2=0x8001 (bypass path).
- Channel 3 even sample stored, then sync_in=1 with a valid chn-3 sample 0x0AAA, then chn-3 sample 0x0BBB -> one beat only: dp1=0x0AAA, dp2=0x0BBB; sync_out=1 exactly 2 cycles after sync_in.
- din_dv=1 with din_chn=40 -> err_chn=1 two cycles later, dout_dv=0, and the phase of all channels is unchanged.
- Random din_dv gaps (50% duty), random channel order, compared against a reference model -> all pairs bit-exact, no lost or extra beats.
- rst_n=0 for 1 cycle while channel 7 has phase=1 and an output beat is in flight -> no beat emitted; next chn-7 sample is treated as even; all outputs 0 during reset.
